// File: rtl/as_rv32i_tohost_uart.sv
// as_rv32i_tohost_uart: Wishbone console UART (8N1, FIFO-buffered) plus riscv-tests tohost exit latch.
// Define TOHOST_DRAIN_EN to hold o_done/o_pass until the console FIFO and transmitter have drained.
module as_rv32i_tohost_uart #(
    parameter int CLK_FREQ_MHZ = 100,
    parameter int BAUD_RATE    = 115200,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_ack,
    output logic        o_wb_stall,
    output logic [31:0] o_wb_data,
    output logic        o_uart_tx,
    output logic        o_done,
    output logic        o_pass,
    output logic [30:0] o_exit_code
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] DIV_RST = 16'(CLK_FREQ_MHZ * 1000000 / BAUD_RATE);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic          r_wv;
    logic [1:0]    r_wa;
    logic [31:0]   r_wd;
    logic [3:0]    r_ws;
    logic          r_ack;
    logic [31:0]   r_rdata;
    logic [AW:0]   r_wp, r_rp;
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [15:0]   r_div, r_cnt;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit;
    state_t        r_state;
    logic          r_tx, r_ovf, r_latched, r_done, r_pass;
    logic [30:0]   r_code;

    logic          w_req, w_empty, w_full, w_tick, w_pop, w_push, w_push_ok, w_th_wr;
    logic [31:0]   w_thd, w_status, w_rd;
    logic [15:0]   w_div_new;
    logic          w_unused;

    assign w_req     = i_wb_cyc & i_wb_stb;
    assign w_empty   = r_wp == r_rp;
    assign w_full    = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_tick    = r_cnt == 16'd0;
    assign w_pop     = !w_empty && (r_state == IDLE || (r_state == STOP && w_tick));
    assign w_push    = r_wv && r_wa == 2'd0 && r_ws[0];
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_thd     = r_wd & {{8{r_ws[3]}}, {8{r_ws[2]}}, {8{r_ws[1]}}, {8{r_ws[0]}}};
    assign w_th_wr   = r_wv && r_wa == 2'd2 && w_thd[0] && !r_latched;
    assign w_div_new = {r_ws[1] ? r_wd[15:8] : r_div[15:8], r_ws[0] ? r_wd[7:0] : r_div[7:0]};
    assign w_status  = {27'd0, r_ovf, r_done, r_state != IDLE, w_empty, w_full};
    assign w_rd      = i_wb_addr[3:2] == 2'd1 ? w_status :
                       i_wb_addr[3:2] == 2'd2 ? {r_code, r_done} :
                       i_wb_addr[3:2] == 2'd3 ? {16'd0, r_div} : 32'd0;
    assign w_unused  = ^{i_wb_addr[31:4], i_wb_addr[1:0]};

    assign o_wb_ack    = r_ack;
    assign o_wb_stall  = 1'b0;
    assign o_wb_data   = r_rdata;
    assign o_uart_tx   = r_tx;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_exit_code = r_code;

    // Writes are applied one cycle after the request, i.e. at the end of the ack cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack     <= 1'b0;
            r_rdata   <= 32'd0;
            r_wv      <= 1'b0;
            r_wa      <= 2'd0;
            r_wd      <= 32'd0;
            r_ws      <= 4'd0;
            r_div     <= DIV_RST;
            r_ovf     <= 1'b0;
            r_latched <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_code    <= 31'd0;
        end else begin
            r_ack   <= w_req;
            r_rdata <= (w_req && !i_wb_we) ? w_rd : 32'd0;
            r_wv    <= w_req && i_wb_we;
            r_wa    <= i_wb_addr[3:2];
            r_wd    <= i_wb_data;
            r_ws    <= i_wb_sel;
            if (r_wv && r_wa == 2'd3)
                r_div <= w_div_new == 16'd0 ? 16'd1 : w_div_new;
            if (r_wv && r_wa == 2'd1 && |r_ws)
                r_ovf <= 1'b0;
            else if (w_push && !w_push_ok)
                r_ovf <= 1'b1;
`ifdef TOHOST_DRAIN_EN
            if (w_th_wr) begin
                r_latched <= 1'b1;
                r_code    <= w_thd[31:1];
            end
            if (r_latched && !r_done && w_empty && r_state == IDLE) begin
                r_done <= 1'b1;
                r_pass <= r_code == 31'd0;
            end
`else
            if (w_th_wr) begin
                r_latched <= 1'b1;
                r_code    <= w_thd[31:1];
                r_done    <= 1'b1;
                r_pass    <= w_thd[31:1] == 31'd0;
            end
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push_ok)
            r_mem[r_wp[AW-1:0]] <= r_wd[7:0];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push_ok)
                r_wp <= r_wp + (AW+1)'(1);
            if (w_pop)
                r_rp <= r_rp + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_tx    <= 1'b1;
            r_cnt   <= 16'd0;
            r_shift <= 8'd0;
            r_bit   <= 3'd0;
        end else begin
            // The divisor is sampled only when a bit period (re)starts.
            r_cnt <= (r_state == IDLE || w_tick) ? r_div - 16'd1 : r_cnt - 16'd1;
            case (r_state)
                IDLE: if (w_pop) begin
                    r_shift <= r_mem[r_rp[AW-1:0]];
                    r_tx    <= 1'b0;
                    r_state <= START;
                end
                START: if (w_tick) begin
                    r_tx    <= r_shift[0];
                    r_bit   <= 3'd0;
                    r_state <= DATA;
                end
                DATA: if (w_tick) begin
                    if (r_bit == 3'd7) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end else begin
                        r_shift <= r_shift >> 1;
                        r_tx    <= r_shift[1];
                        r_bit   <= r_bit + 3'd1;
                    end
                end
                STOP: if (w_tick) begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rp[AW-1:0]];
                        r_tx    <= 1'b0;
                        r_state <= START;
                    end else begin
                        r_state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_as_rv32i_tohost_uart.sv
// tb_as_rv32i_tohost_uart: directed bench with a UART receiver feeding a byte scoreboard.
module tb_as_rv32i_tohost_uart;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [3:0]  sel = 4'd0;
    logic        ack, stall, tx, done, pass;
    logic [31:0] rdata;
    logic [30:0] exit_code;

    int          checks = 0;
    int          errors = 0;
    int          rx_count = 0;
    int          tb_div = 868;
    logic [7:0]  exp_q[$];

    localparam logic [31:0] A_TX = 32'h0, A_ST = 32'h4, A_TH = 32'h8, A_BD = 32'hC;

    as_rv32i_tohost_uart dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel), .o_wb_ack(ack),
        .o_wb_stall(stall), .o_wb_data(rdata), .o_uart_tx(tx), .o_done(done),
        .o_pass(pass), .o_exit_code(exit_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] r);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("ack", {31'd0, ack}, 32'd1);
        chk("stall", {31'd0, stall}, 32'd0);
        r = rdata;
        if (w) chk("wr_data_zero", rdata, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        xfer(1'b1, a, d, 4'hF, r);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, a, 32'd0, 4'hF, r);
        chk(tag, r, exp);
    endtask

    task automatic send(input logic [7:0] b);
        exp_q.push_back(b);
        wr(A_TX, {24'd0, b});
    endtask

    task automatic wait_rx(input int n, input int budget);
        int c = 0;
        while (rx_count < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("rx_count", rx_count, n);
    endtask

    // Receiver: samples each bit at its middle, using the divisor the bench last programmed.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tx === 1'b0) begin
                int d;
                logic [7:0] b;
                d = tb_div;
                repeat (d / 2) @(negedge clk);
                chk("rx_start", {31'd0, tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = tx;
                end
                repeat (d) @(negedge clk);
                chk("rx_stop", {31'd0, tx}, 32'd1);
                chk("rx_pending", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) chk("rx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
                rx_count++;
            end
        end
    end

    initial begin
        logic [7:0] pat;
        logic       eb;
        int         c;
        pat = 8'h55;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pass", {31'd0, pass}, 32'd0);
        chk("rst_exit", {1'b0, exit_code}, 32'd0);
        rst_n = 1'b1;
        rd_chk("status_idle", A_ST, 32'h2);
        @(negedge clk);
        chk("ack_one_cycle", {31'd0, ack}, 32'd0);
        rd_chk("baud_reset", A_BD, 32'd868);

        wr(A_BD, 32'd4);
        tb_div = 4;
        rd_chk("baud_4", A_BD, 32'd4);
        send(8'h55);
        c = 0;
        while (tx !== 1'b0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("frame_start_seen", {31'd0, tx}, 32'd0);
        for (int i = 0; i <= 40; i++) begin
            eb = (i < 4) ? 1'b0 : (i < 36) ? pat[(i - 4) / 4] : 1'b1;
            chk($sformatf("wave_%0d", i), {31'd0, tx}, {31'd0, eb});
            @(negedge clk);
        end
        wait_rx(1, 100);
        send(8'hA3);
        repeat (3) @(negedge clk);
        rd_chk("status_busy", A_ST, 32'h6);
        wait_rx(2, 200);

        wr(A_BD, 32'd0);
        rd_chk("baud_zero", A_BD, 32'd1);
        wr(A_BD, 32'd100);
        begin
            logic [31:0] r;
            xfer(1'b1, A_BD, 32'h1234, 4'b0001, r);
        end
        rd_chk("baud_sel0", A_BD, 32'h34);
        wr(A_BD, 32'd100);
        tb_div = 100;

        for (int i = 0; i < 18; i++) begin
            if (i < 17) exp_q.push_back(8'(i));
            wr(A_TX, i);
        end
        rd_chk("status_ovf", A_ST, 32'h15);
        wr(A_ST, 32'd0);
        rd_chk("status_ovf_clr", A_ST, 32'h05);
        wait_rx(19, 20000);
        repeat (150) @(negedge clk);
        rd_chk("status_drained", A_ST, 32'h2);
        chk("queue_empty", exp_q.size(), 32'd0);

        wr(A_TH, 32'h1);
`ifndef TOHOST_DRAIN_EN
        chk("done_not_in_ack", {31'd0, done}, 32'd0);
`endif
        @(negedge clk);
        chk("pass_done", {31'd0, done}, 32'd1);
        chk("pass_pass", {31'd0, pass}, 32'd1);
        chk("pass_exit", {1'b0, exit_code}, 32'd0);
        wr(A_TH, 32'h7);
        repeat (2) @(negedge clk);
        chk("ignored_exit", {1'b0, exit_code}, 32'd0);
        chk("ignored_pass", {31'd0, pass}, 32'd1);
        rd_chk("tohost_rd_pass", A_TH, 32'h1);

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst2_done", {31'd0, done}, 32'd0);
        chk("rst2_tx", {31'd0, tx}, 32'd1);
        rst_n = 1'b1;
        wr(A_TH, 32'h4);
        repeat (2) @(negedge clk);
        chk("even_ignored", {31'd0, done}, 32'd0);
        wr(A_TH, 32'hB);
        @(negedge clk);
        chk("fail_done", {31'd0, done}, 32'd1);
        chk("fail_pass", {31'd0, pass}, 32'd0);
        chk("fail_exit", {1'b0, exit_code}, 32'd5);
        rd_chk("tohost_rd_fail", A_TH, 32'hB);
        rd_chk("status_done", A_ST, 32'hA);

`ifdef TOHOST_DRAIN_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rx_count = 0;
        wr(A_BD, 32'd4);
        tb_div = 4;
        send(8'h3C);
        send(8'hC3);
        wr(A_TH, 32'h1);
        repeat (2) @(negedge clk);
        chk("drain_pending", {31'd0, done}, 32'd0);
        c = 0;
        while (done !== 1'b1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("drain_done", {31'd0, done}, 32'd1);
        chk("drain_rx", rx_count, 32'd2);
        chk("drain_pass", {31'd0, pass}, 32'd1);
        chk("drain_tx_idle", {31'd0, tx}, 32'd1);
`endif

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
